// File: rtl/ahb_param_decoder.sv
// Parametrised AHB address decoder: per-master region decode, registered
// data-phase selects and a per-master default slave with an error counter.
module ahb_param_decoder #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int REGION_BITS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                              HCLK,
    input  logic                              HRESET,
    input  logic [NUM_MASTERS*32-1:0]         HADDR,
    input  logic [NUM_MASTERS*2-1:0]          HTRANS,
    input  logic [NUM_MASTERS-1:0]            HREADY,
    input  logic [NUM_MASTERS-1:0]            ERR_CLR,
    output logic [NUM_MASTERS*NUM_SLAVES-1:0] HSEL,
    output logic [NUM_MASTERS*NUM_SLAVES-1:0] HSEL_DP,
    output logic [NUM_MASTERS-1:0]            HSEL_DEF_DP,
    output logic [NUM_MASTERS-1:0]            DEF_HREADYOUT,
    output logic [NUM_MASTERS-1:0]            DEF_HRESP,
    output logic [NUM_MASTERS*CNT_W-1:0]      ERR_CNT
);

    // State encoding doubles as the output register: bit0 = HREADYOUT, bit1 = HRESP.
    localparam logic [1:0] S_IDLE = 2'b01;
    localparam logic [1:0] S_ERR1 = 2'b10;
    localparam logic [1:0] S_ERR2 = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    genvar m, s;
    generate
        for (m = 0; m < NUM_MASTERS; m++) begin : g_m
            logic [REGION_BITS-1:0] w_region;
            logic [NUM_SLAVES-1:0]  w_hsel;
            logic                   w_miss;
            logic                   w_act;
            logic [1:0]             w_state_nxt;
            logic [1:0]             r_state;
            logic [NUM_SLAVES-1:0]  r_hsel_dp;
            logic                   r_def_dp;
            logic [CNT_W-1:0]       r_cnt;

            assign w_region = HADDR[m*32+32-REGION_BITS +: REGION_BITS];

            for (s = 0; s < NUM_SLAVES; s++) begin : g_s
                assign w_hsel[s] = (w_region == REGION_BITS'(s));
            end

            assign w_miss = ~|w_hsel;
            assign w_act  = HREADY[m] & HTRANS[m*2+1] & w_miss;

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    S_IDLE:  if (w_act) w_state_nxt = S_ERR1;
                    S_ERR1:  w_state_nxt = S_ERR2;
                    S_ERR2:  w_state_nxt = w_act ? S_ERR1 : S_IDLE;
                    default: w_state_nxt = S_IDLE;
                endcase
            end

            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) r_state <= S_IDLE;
                else        r_state <= w_state_nxt;
            end

            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    r_hsel_dp <= '0;
                    r_def_dp  <= 1'b0;
                end else if (HREADY[m]) begin
                    r_hsel_dp <= w_hsel;
                    r_def_dp  <= w_miss;
                end
            end

            // Every ERR1 leaves for ERR2 on the next edge, so count on ERR1 residency.
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET)                                 r_cnt <= '0;
                else if (ERR_CLR[m])                        r_cnt <= '0;
                else if (r_state == S_ERR1 && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end

            assign HSEL[m*NUM_SLAVES +: NUM_SLAVES]    = w_hsel;
            assign HSEL_DP[m*NUM_SLAVES +: NUM_SLAVES] = r_hsel_dp;
            assign HSEL_DEF_DP[m]                      = r_def_dp;
            assign DEF_HREADYOUT[m]                    = r_state[0];
            assign DEF_HRESP[m]                        = r_state[1];
            assign ERR_CNT[m*CNT_W +: CNT_W]           = r_cnt;
        end
    endgenerate

endmodule
